// File: rtl/d_fifo_reader.sv
// ---------------------------------------------------------------------------
// d_fifo_reader
//
// Read-side controller for the D-class FIFO pair (D0, D1) in the transmit
// path. It watches both FIFO empty flags and the downstream pause flag, and
// issues at most one single-cycle read enable per clock. It captures the
// FIFO's registered read data one cycle after the enable and presents one
// merged, registered output stream with a valid qualifier.
//
// Read-to-output latency is fixed at 2 cycles:
//   rd_enable at N -> FIFO data at N+1 -> data_out/valid_out at N+2.
//
// Arbitration:
//   default  : round-robin between non-empty FIFOs; D0 wins the first tie
//              after reset.
//   D_FIFO_READER_STRICT_PRIO_EN defined : D0 has strict priority and D1 is
//              read only while D0 is empty. last_grant is still tracked.
//
// Parameters:
//   data_width    word width of both FIFOs and of the output stream
//
// Ports:
//   clk           rising-edge clock
//   reset_L       synchronous active-low reset
//   init          block enable; low behaves exactly like reset
//   empty_D0/D1   FIFO empty flags
//   data_in_D0/D1 FIFO registered read data, valid the cycle after rd_enable
//   pause         downstream almost-full; blocks new reads only
//   rd_enable_D0/D1  single-cycle pop requests
//   data_out      merged output word (0 when not valid)
//   valid_out     data_out qualifier
//   idle_out      both FIFOs empty and nothing in flight
// ---------------------------------------------------------------------------
module d_fifo_reader #(
    parameter int data_width = 6
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic                  empty_D0,
    input  logic                  empty_D1,
    input  logic [data_width-1:0] data_in_D0,
    input  logic [data_width-1:0] data_in_D1,
    input  logic                  pause,
    output logic                  rd_enable_D0,
    output logic                  rd_enable_D1,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out,
    output logic                  idle_out
);

    // Arbitration history: 0 = D0 was granted last, 1 = D1.
    logic                  r_lastGrant;
    // Stage 1: a read was issued last cycle, and from which FIFO.
    logic                  r_pending;
    logic                  r_source;
    // Stage 2: registered output stream.
    logic [data_width-1:0] r_dataOut;
    logic                  r_validOut;

    logic                  w_active;
    logic                  w_canIssue;
    logic                  w_grant;
    logic                  w_grantSrc;

    assign w_active   = reset_L & init;
    assign w_canIssue = w_active & ~pause;

    // Choose which FIFO to read this cycle. A FIFO that is empty can never
    // be granted, so the enables below are safe by construction; the extra
    // ~empty terms on the enables keep that true even if the grant logic is
    // later changed.
    always_comb begin
        w_grant    = 1'b0;
        w_grantSrc = 1'b0;
`ifdef D_FIFO_READER_STRICT_PRIO_EN
        if (!empty_D0) begin
            w_grant    = 1'b1;
            w_grantSrc = 1'b0;
        end else if (!empty_D1) begin
            w_grant    = 1'b1;
            w_grantSrc = 1'b1;
        end
`else
        if (!empty_D0 && !empty_D1) begin
            // Tie: serve the FIFO that was not served last time.
            w_grant    = 1'b1;
            w_grantSrc = ~r_lastGrant;
        end else if (!empty_D0) begin
            w_grant    = 1'b1;
            w_grantSrc = 1'b0;
        end else if (!empty_D1) begin
            w_grant    = 1'b1;
            w_grantSrc = 1'b1;
        end
`endif
        if (!w_canIssue) begin
            w_grant = 1'b0;
        end
    end

    assign rd_enable_D0 = w_grant & ~w_grantSrc & ~empty_D0;
    assign rd_enable_D1 = w_grant &  w_grantSrc & ~empty_D1;

    // Issue and capture pipeline. Reset (or init low) drops anything in
    // flight, so a word popped just before reset never shows up as valid.
    // last_grant resets to D1 so that D0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!w_active) begin
            r_lastGrant <= 1'b1;
            r_pending   <= 1'b0;
            r_source    <= 1'b0;
            r_dataOut   <= '0;
            r_validOut  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_lastGrant <= w_grantSrc;
                r_pending   <= 1'b1;
                r_source    <= w_grantSrc;
            end else begin
                r_pending   <= 1'b0;
            end

            if (r_pending) begin
                r_dataOut  <= r_source ? data_in_D1 : data_in_D0;
                r_validOut <= 1'b1;
            end else begin
                r_dataOut  <= '0;
                r_validOut <= 1'b0;
            end
        end
    end

    assign data_out  = r_dataOut;
    assign valid_out = r_validOut;

    // Idle only when both FIFOs are empty and neither pipeline stage holds
    // a word; forced low while the block is held in reset.
    assign idle_out = w_active & empty_D0 & empty_D1 & ~r_pending & ~r_validOut;

endmodule

// File: tb/tb_d_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_d_fifo_reader
//
// Drives d_fifo_reader from two queue-based FIFO models and compares every
// cycle against a reference built from the arbitration rules: a grant
// decision per cycle and a two-slot delay line for the output stream.
// Honours D_FIFO_READER_STRICT_PRIO_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_d_fifo_reader;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset_L;
    logic         init;
    logic         empty_D0;
    logic         empty_D1;
    logic [W-1:0] data_in_D0;
    logic [W-1:0] data_in_D1;
    logic         pause;
    logic         rd_enable_D0;
    logic         rd_enable_D1;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         idle_out;

    always #5 clk = ~clk;

    d_fifo_reader #(.data_width(W)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .init         (init),
        .empty_D0     (empty_D0),
        .empty_D1     (empty_D1),
        .data_in_D0   (data_in_D0),
        .data_in_D1   (data_in_D1),
        .pause        (pause),
        .rd_enable_D0 (rd_enable_D0),
        .rd_enable_D1 (rd_enable_D1),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .idle_out     (idle_out)
    );

    // FIFO contents and the log of words seen on the output.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] outLog[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference state: who was served last, and the two words in flight
    // (s1 = read issued last cycle, s0 = what the output shows now).
    logic         mLast;
    logic         s0v, s1v;
    logic [W-1:0] s0d, s1d;
    // Reference decision for the current cycle.
    logic         mGrant;
    logic         mSrc;
    logic [W-1:0] mWord;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Decide which FIFO ought to be read this cycle from the current
    // FIFO occupancy, pause, reset and arbitration history.
    task automatic computeExpected;
        logic ne0, ne1;
        ne0    = (q0.size() != 0);
        ne1    = (q1.size() != 0);
        mGrant = 1'b0;
        mSrc   = 1'b0;
        mWord  = '0;
`ifdef D_FIFO_READER_STRICT_PRIO_EN
        if (ne0) begin
            mGrant = 1'b1; mSrc = 1'b0;
        end else if (ne1) begin
            mGrant = 1'b1; mSrc = 1'b1;
        end
`else
        if (ne0 && ne1) begin
            mGrant = 1'b1; mSrc = ~mLast;
        end else if (ne0) begin
            mGrant = 1'b1; mSrc = 1'b0;
        end else if (ne1) begin
            mGrant = 1'b1; mSrc = 1'b1;
        end
`endif
        if (!(reset_L && init && !pause)) mGrant = 1'b0;
        if (mGrant) mWord = mSrc ? q1[0] : q0[0];
    endtask

    task automatic checkCycle;
        computeExpected();
        checkOutput("rdEn0", 32'(rd_enable_D0), 32'(mGrant & ~mSrc));
        checkOutput("rdEn1", 32'(rd_enable_D1), 32'(mGrant & mSrc));
        checkOutput("readWhileEmpty",
                    32'((rd_enable_D0 & empty_D0) | (rd_enable_D1 & empty_D1)), 32'd0);
        checkOutput("valid", 32'(valid_out), 32'(s0v));
        checkOutput("data", 32'(data_out), 32'(s0v ? s0d : '0));
        checkOutput("idle", 32'(idle_out),
                    32'(reset_L & init & empty_D0 & empty_D1 & ~s1v & ~s0v));
        if (valid_out === 1'b1) outLog.push_back(data_out);
    endtask

    // One clock: advance FIFOs and reference across the edge, apply the
    // next inputs shortly after it, then check the settled outputs.
    task automatic applyStimulus(input logic rL, input logic in, input logic ps,
                                 input logic p0, input logic [W-1:0] v0,
                                 input logic p1, input logic [W-1:0] v1);
        logic en0, en1, act;
        en0 = rd_enable_D0;
        en1 = rd_enable_D1;
        act = reset_L & init;
        @(posedge clk);
        #1;
        if (en0 === 1'b1 && q0.size() > 0) data_in_D0 = q0.pop_front();
        if (en1 === 1'b1 && q1.size() > 0) data_in_D1 = q1.pop_front();
        if (!act) begin
            s0v = 1'b0; s1v = 1'b0; s0d = '0; s1d = '0; mLast = 1'b1;
        end else begin
            s0v = s1v; s0d = s1d;
            s1v = mGrant; s1d = mWord;
            if (mGrant) mLast = mSrc;
        end
        reset_L = rL;
        init    = in;
        pause   = ps;
        if (p0) q0.push_back(v0);
        if (p1) q1.push_back(v1);
        empty_D0 = (q0.size() == 0);
        empty_D1 = (q1.size() == 0);
        #1;
        checkCycle();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    logic [W-1:0] rrExp [4];

    initial begin
        reset_L = 1'b0; init = 1'b0; pause = 1'b0;
        empty_D0 = 1'b1; empty_D1 = 1'b1;
        data_in_D0 = '0; data_in_D1 = '0;
        mLast = 1'b1; s0v = 1'b0; s1v = 1'b0; s0d = '0; s1d = '0;
        mGrant = 1'b0; mSrc = 1'b0; mWord = '0;

        // Held in reset with both FIFOs filling, then reset released but
        // init low: nothing may be read and nothing is idle.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'($urandom_range(0, 63)),
                          1'b1, 6'($urandom_range(0, 63)));
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        idleCycles(10);

        // Single word through D0.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'h2A, 1'b0, '0);
        idleCycles(4);

        // Interleaving of two words per FIFO, loaded while paused.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 6'h01, 1'b1, 6'h11);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 6'h02, 1'b1, 6'h12);
        outLog.delete();
        idleCycles(7);
`ifdef D_FIFO_READER_STRICT_PRIO_EN
        rrExp[0] = 6'h01; rrExp[1] = 6'h02; rrExp[2] = 6'h11; rrExp[3] = 6'h12;
`else
        rrExp[0] = 6'h01; rrExp[1] = 6'h11; rrExp[2] = 6'h02; rrExp[3] = 6'h12;
`endif
        checkOutput("orderCount", 32'(outLog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("order%0d", i),
                        32'(i < outLog.size() ? outLog[i] : '1), 32'(rrExp[i]));

        // Pause mid-stream, then release.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'($urandom_range(0, 63)),
                          1'b1, 6'($urandom_range(0, 63)));
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        idleCycles(12);

        // A single word in D1 with D0 empty.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 6'h33);
        idleCycles(3);
        idleCycles(3);

        // Reset one cycle after a read, then a tie after release.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'h15, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'h21, 1'b1, 6'h31);
        idleCycles(6);

        // Randomized traffic with occasional pause, reset and init drops.
        for (int i = 0; i < 500; i++)
            applyStimulus(1'($urandom_range(0, 49) != 0),
                          1'($urandom_range(0, 49) != 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 63)),
                          1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 63)));
        idleCycles(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
